contador_lector: RTL and testbench



---
 rtl/contador_lector_pkg.sv | 18 +
 rtl/contador_lector_prio.sv | 24 ++
 rtl/contador_lector.sv | 196 +++++++++++++++++++
 tb/tb_contador_lector.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/contador_lector_pkg.sv
// Shared types and constants for the counter readout sequencer.
package contador_lector_pkg;

    localparam int NUM_CH      = 4;
    localparam int IDX_W       = 2;
    localparam int TMR_W       = 8;
    localparam int TIMEOUT_DEF = 8;
    localparam int CBITS_DEF   = 5;

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_REQ   = 3'd1,
        S_CAPT  = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

endpackage

// File: rtl/contador_lector_prio.sv
// Next-enabled-channel finder: lowest set mask bit strictly above ptr.
// Latency: combinational; no backpressure.
module contador_lector_prio
    import contador_lector_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  next_ptr,
    output logic              none_left
);

    // Descending scan so the lowest qualifying bit is the one that sticks.
    always_comb begin
        next_ptr  = '0;
        none_left = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(ptr))) begin
                next_ptr  = IDX_W'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/contador_lector.sv
// Readout sequencer: sweeps enabled counter channels, publishes an atomic snapshot.
// Latency: 1 + 2 cycles per enabled channel to done; waits up to TIMEOUT cycles per valid, aborts on idle loss.
module contador_lector
    import contador_lector_pkg::*;
#(
    parameter int CBITS   = CBITS_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NUM_CH-1:0] chan_mask,
    input  logic              idle,
    input  logic [CBITS-1:0]  counter_in,
    input  logic              valid_in,
    output logic              req,
    output logic [IDX_W-1:0]  idx,
    output logic [CBITS-1:0]  snap0,
    output logic [CBITS-1:0]  snap1,
    output logic [CBITS-1:0]  snap2,
    output logic [CBITS-1:0]  snap3,
    output logic              busy,
    output logic              done,
    output logic              abort
);

    state_t               state_q, state_d;
    logic [NUM_CH-1:0]    mask_q, mask_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 req_q, req_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 abort_q, abort_d;
    logic [CBITS-1:0]     shadow_q [NUM_CH];
    logic [CBITS-1:0]     shadow_d [NUM_CH];
    logic [CBITS-1:0]     snap_q   [NUM_CH];
    logic [CBITS-1:0]     snap_d   [NUM_CH];

    logic [IDX_W-1:0]     nxt_ptr;
    logic                 nxt_none;
    logic [IDX_W-1:0]     fst_above;
    logic                 fst_none_above;
    logic [IDX_W-1:0]     first_ptr;
    logic                 mask_empty;

    contador_lector_prio u_next (
        .mask      (mask_q),
        .ptr       (ptr_q),
        .next_ptr  (nxt_ptr),
        .none_left (nxt_none)
    );

    // Lowest set bit = bit 0 if set, otherwise the first set bit above 0.
    contador_lector_prio u_first (
        .mask      (chan_mask),
        .ptr       ('0),
        .next_ptr  (fst_above),
        .none_left (fst_none_above)
    );

    assign first_ptr  = chan_mask[0] ? '0 : fst_above;
    assign mask_empty = !chan_mask[0] && fst_none_above;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        ptr_d    = ptr_q;
        timer_d  = timer_q;
        req_d    = req_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        shadow_d = shadow_q;
        snap_d   = snap_q;

        case (state_q)
            S_WAIT: begin
                req_d = 1'b0;
                if (start && idle) begin
                    if (mask_empty) begin
                        mask_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        mask_d  = chan_mask;
                        ptr_d   = first_ptr;
                        busy_d  = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end

            S_REQ: begin
                if (!idle) begin
                    req_d   = 1'b0;
                    state_d = S_ABORT;
                end else begin
                    req_d   = 1'b1;
                    idx_d   = ptr_q;
                    timer_d = '0;
                    state_d = S_CAPT;
                end
            end

            // A returned value is captured even if idle drops in the same cycle.
            S_CAPT: begin
                if (valid_in) begin
                    shadow_d[ptr_q] = counter_in;
                    req_d           = 1'b0;
                    if (nxt_none) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = nxt_ptr;
                        state_d = S_REQ;
                    end
                end else if (!idle) begin
                    req_d   = 1'b0;
                    state_d = S_ABORT;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    state_d = S_ABORT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            S_DONE: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (mask_q[i]) begin
                        snap_d[i] = shadow_q[i];
                    end
                end
                done_d  = 1'b1;
                req_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_WAIT;
            end

            S_ABORT: begin
                abort_d = 1'b1;
                req_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_WAIT;
            end

            default: begin
                req_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            mask_q  <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
            req_q   <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                snap_q[i]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            ptr_q    <= ptr_d;
            timer_q  <= timer_d;
            req_q    <= req_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            shadow_q <= shadow_d;
            snap_q   <= snap_d;
        end
    end

    assign req   = req_q;
    assign idx   = idx_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign abort = abort_q;
    assign snap0 = snap_q[0];
    assign snap1 = snap_q[1];
    assign snap2 = snap_q[2];
    assign snap3 = snap_q[3];

endmodule

// File: tb/tb_contador_lector.sv
// Randomized bench for contador_lector with a sweep-level reference model.
module tb_contador_lector;

    localparam int CB = 5;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    chan_mask;
    logic          idle;
    logic [CB-1:0] counter_in;
    logic          valid_in;
    logic          req;
    logic [1:0]    idx;
    logic [CB-1:0] snap0, snap1, snap2, snap3;
    logic          busy, done, abort;

    logic [CB-1:0] cnt [4];
    logic [3:0]    vld_en;
    int            model_snap [4];
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    // Counter block model: answers a request in the same cycle unless silenced.
    assign counter_in = cnt[idx];
    assign valid_in   = req & vld_en[idx];

    contador_lector #(.CBITS(CB), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .chan_mask  (chan_mask),
        .idle       (idle),
        .counter_in (counter_in),
        .valid_in   (valid_in),
        .req        (req),
        .idx        (idx),
        .snap0      (snap0),
        .snap1      (snap1),
        .snap2      (snap2),
        .snap3      (snap3),
        .busy       (busy),
        .done       (done),
        .abort      (abort)
    );

    task automatic chk_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int snap_of(input int i);
        case (i)
            0:       return int'(snap0);
            1:       return int'(snap1);
            2:       return int'(snap2);
            default: return int'(snap3);
        endcase
    endfunction

    // mode: 0 clean, 1 idle drop during channel k, 2 channel k silent, 3 reset during k, 4 start while not idle
    task automatic run_sweep(input logic [3:0] m, input int mode, input int k, input bit vld_k);
        int  ids[$];
        int  exp_req[$];
        int  got_req[$];
        int  n, j, exp_done, exp_abort, exp_busy;
        int  done_t, abort_t, done_n, abort_n, busy_n;
        bit  upd, req_prev;
        for (int i = 0; i < 4; i++) if (m[i]) ids.push_back(i);
        n = ids.size();
        j = n;
        for (int i = 0; i < n; i++) if (ids[i] == k) j = i;
        exp_done  = -1;
        exp_abort = -1;
        exp_busy  = 0;
        upd       = 1'b0;
        if (mode == 0) begin
            exp_req  = ids;
            exp_done = 2 * n + 1;
            upd      = 1'b1;
            exp_busy = (n == 0) ? 0 : exp_done;
        end else if (mode >= 1 && mode <= 3) begin
            for (int i = 0; i <= j; i++) exp_req.push_back(ids[i]);
            if (mode == 1 && vld_k && j == n - 1) begin
                exp_done = 2 * j + 3;
                upd      = 1'b1;
            end else if (mode == 1 && vld_k) begin
                exp_abort = 2 * j + 4;
            end else if (mode == 1) begin
                exp_abort = 2 * j + 3;
            end else if (mode == 2) begin
                exp_abort = 2 * j + 2 + TO;
            end
            exp_busy = (mode == 3) ? 2 * j + 2 : ((exp_done >= 0) ? exp_done : exp_abort);
        end

        vld_en = 4'hF;
        if ((mode == 1 && !vld_k) || mode == 2) vld_en[k[1:0]] = 1'b0;
        idle = (mode != 4);
        done_t = -1; abort_t = -1; done_n = 0; abort_n = 0; busy_n = 0;
        req_prev = 1'b0;

        @(negedge clk);
        start     = 1'b1;
        chan_mask = m;
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            if (t == 0) begin
                start     = 1'b0;
                chan_mask = 4'($urandom);
            end
            if (req && !req_prev) got_req.push_back(int'(idx));
            req_prev = req;
            busy_n += int'(busy);
            if (done) begin
                done_n++;
                if (done_t < 0) done_t = t;
            end
            if (abort) begin
                abort_n++;
                if (abort_t < 0) abort_t = t;
            end
            if (mode == 1 && t == 2 * j + 1) idle = 1'b0;
            if (mode == 2) start = (t == 3 || t == 5);
            if (mode == 3 && t == 2 * j + 1) reset = 1'b1;
            if (mode == 3 && t == 2 * j + 2) begin
                chk_val("rst_req", int'(req), 0);
                chk_val("rst_idx", int'(idx), 0);
                chk_val("rst_busy", int'(busy), 0);
                for (int i = 0; i < 4; i++) chk_val($sformatf("rst_snap%0d", i), snap_of(i), 0);
                reset = 1'b0;
                break;
            end
        end
        start = 1'b0;
        idle  = 1'b1;
        reset = 1'b0;

        if (mode == 3) begin
            for (int i = 0; i < 4; i++) model_snap[i] = 0;
        end else if (upd) begin
            foreach (ids[i]) model_snap[ids[i]] = int'(cnt[ids[i]]);
        end

        chk_val($sformatf("m%0d_nreq", mode), got_req.size(), exp_req.size());
        for (int i = 0; i < exp_req.size() && i < got_req.size(); i++)
            chk_val($sformatf("m%0d_req%0d_idx", mode, i), got_req[i], exp_req[i]);
        chk_val($sformatf("m%0d_done_t", mode), done_t, exp_done);
        chk_val($sformatf("m%0d_abort_t", mode), abort_t, exp_abort);
        chk_val($sformatf("m%0d_done_n", mode), done_n, (exp_done >= 0) ? 1 : 0);
        chk_val($sformatf("m%0d_abort_n", mode), abort_n, (exp_abort >= 0) ? 1 : 0);
        chk_val($sformatf("m%0d_busy_n", mode), busy_n, exp_busy);
        for (int i = 0; i < 4; i++)
            chk_val($sformatf("m%0d_snap%0d", mode, i), snap_of(i), model_snap[i]);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int m_i, mode_i, k_i;
        reset     = 1'b1;
        start     = 1'b0;
        idle      = 1'b1;
        chan_mask = 4'h0;
        vld_en    = 4'hF;
        for (int i = 0; i < 4; i++) begin
            cnt[i]        = '0;
            model_snap[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk_val("reset_req", int'(req), 0);
        chk_val("reset_idx", int'(idx), 0);
        chk_val("reset_busy", int'(busy), 0);
        chk_val("reset_done", int'(done), 0);
        chk_val("reset_abort", int'(abort), 0);
        for (int i = 0; i < 4; i++) chk_val($sformatf("reset_snap%0d", i), snap_of(i), 0);
        reset = 1'b0;
        @(negedge clk);

        cnt[0] = 5'd1; cnt[1] = 5'd2; cnt[2] = 5'd3; cnt[3] = 5'd4;
        run_sweep(4'hF, 0, 0, 1'b0);
        run_sweep(4'hF, 4, 0, 1'b0);
        cnt[0] = cnt[0] + 5'd10;
        run_sweep(4'h5, 0, 0, 1'b0);
        run_sweep(4'hF, 1, 2, 1'b0);
        run_sweep(4'hF, 2, 1, 1'b0);
        run_sweep(4'hF, 3, 3, 1'b0);
        run_sweep(4'hF, 0, 0, 1'b0);
        run_sweep(4'h0, 0, 0, 1'b0);
        run_sweep(4'hF, 1, 3, 1'b1);
        run_sweep(4'hA, 1, 1, 1'b1);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 4; i++) cnt[i] = CB'($urandom);
            m_i    = $urandom_range(0, 15);
            mode_i = $urandom_range(0, 4);
            k_i    = 0;
            if (m_i == 0 && mode_i >= 1 && mode_i <= 3) mode_i = 0;
            if (m_i != 0) begin
                do k_i = $urandom_range(0, 3); while (!m_i[k_i]);
            end
            run_sweep(4'(m_i), mode_i, k_i, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
